wr_phy_link_ctrl: RTL and testbench

Link bring-up controller and TX-path arbiter for the 1000BASE-X PHY in the WR endpoint.
- Resets the PHY and waits for it to report ready.
- Trains the link with 8b/10b idle ordered sets until the receiver sees a stable idle stream.
- Hands the PHY TX path to the MAC, inserting idles whenever the MAC has nothing to send.
- Monitors RX code errors and PHY readiness, and retrains the link when either fails.

---
 rtl/wr_phy_link_ctrl_if.sv | 37 +++
 rtl/wr_phy_link_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_wr_phy_link_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_phy_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_phy_link_ctrl_if
// Description : MAC-side bus of the WR endpoint PHY link controller.
//               Carries the MAC TX word handshake into the controller and the
//               forwarded RX word stream back out to the MAC.
//               The _i/_o suffixes name the direction seen by the controller.
// Signals     : mac_tx_data_i[15:0]  MAC TX word
//               mac_tx_k_i[1:0]      MAC TX K flags
//               mac_tx_valid_i       MAC word valid
//               mac_tx_ready_o       controller accepts the MAC word
//               mac_rx_data_o[15:0]  RX word forwarded to the MAC
//               mac_rx_k_o[1:0]      RX K flags forwarded to the MAC
//               mac_rx_valid_o       RX word valid
// Modports    : master - MAC side, slave - link controller side
// Revision    : 1.0  initial release
// ============================================================================
interface wr_phy_link_ctrl_if;
  logic [15:0] mac_tx_data_i;
  logic [1:0]  mac_tx_k_i;
  logic        mac_tx_valid_i;
  logic        mac_tx_ready_o;
  logic [15:0] mac_rx_data_o;
  logic [1:0]  mac_rx_k_o;
  logic        mac_rx_valid_o;

  modport master (
    output mac_tx_data_i, mac_tx_k_i, mac_tx_valid_i,
    input  mac_tx_ready_o, mac_rx_data_o, mac_rx_k_o, mac_rx_valid_o
  );

  modport slave (
    input  mac_tx_data_i, mac_tx_k_i, mac_tx_valid_i,
    output mac_tx_ready_o, mac_rx_data_o, mac_rx_k_o, mac_rx_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/wr_phy_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wr_phy_link_ctrl
// Description : Link bring-up controller and TX-path arbiter for the
//               1000BASE-X PHY of the WR endpoint. Resets the PHY, waits for
//               it to become ready, trains on K28.5 idle ordered sets, then
//               hands the TX path to the MAC (idles fill the gaps). RX code
//               errors or loss of PHY readiness send the link back to RESET.
// Ports       : clk_ref_i           62.5 MHz reference clock
//               rst_n_i             asynchronous active-low reset
//               enable_i            controller enable, low forces RESET
//               phy_rst_o           PHY reset, active-high
//               phy_rdy_i           PHY ready
//               phy_tx_data_o/k_o   TX word / K flags to the PHY
//               phy_tx_disparity_i  PHY running disparity (1 = positive)
//               phy_rx_data_i/k_i   RX word / K flags from the PHY
//               phy_rx_enc_err_i    RX code or disparity error
//               mac                 MAC-side bus (wr_phy_link_ctrl_if.slave)
//               link_up_o           controller is in LINK_UP
//               fault_o             controller is in FAULT
//               state_o             RESET=0 WAIT_RDY=1 TRAIN=2 LINK_UP=3 FAULT=4
//               loopback_req_i      loopback request
//               phy_loopen_o        PHY serial loopback enable
// Options     : WR_PHY_LINK_CTRL_LOOPBACK_EN - when defined, phy_loopen_o
//               follows loopback_req_i and any change of the request retrains
//               the link; when undefined, loopback is tied off.
// Revision    : 1.0  initial release
// ============================================================================
module wr_phy_link_ctrl #(
  parameter int g_reset_cycles  = 16,
  parameter int g_lock_count    = 64,
  parameter int g_err_threshold = 4,
  parameter int g_timeout       = 65535
) (
  input  wire logic         clk_ref_i,
  input  wire logic         rst_n_i,
  input  wire logic         enable_i,
  output logic              phy_rst_o,
  input  wire logic         phy_rdy_i,
  output logic [15:0]       phy_tx_data_o,
  output logic [1:0]        phy_tx_k_o,
  input  wire logic         phy_tx_disparity_i,
  input  wire logic [15:0]  phy_rx_data_i,
  input  wire logic [1:0]   phy_rx_k_i,
  input  wire logic         phy_rx_enc_err_i,
  wr_phy_link_ctrl_if.slave mac,
  output logic              link_up_o,
  output logic              fault_o,
  output logic [2:0]        state_o,
  input  wire logic         loopback_req_i,
  output logic              phy_loopen_o
);

  localparam logic [19:0] c_reset_cycles  = 20'(g_reset_cycles);
  localparam logic [19:0] c_lock_count    = 20'(g_lock_count);
  localparam logic [19:0] c_err_threshold = 20'(g_err_threshold);
  localparam logic [19:0] c_timeout       = 20'(g_timeout);
  localparam logic [15:0] c_idle_pos      = 16'hBCC5; // K28.5 D5.6
  localparam logic [15:0] c_idle_neg      = 16'hBC50; // K28.5 D16.2
  localparam logic [1:0]  c_idle_k        = 2'b10;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_TRAIN    = 3'd2,
    ST_LINK_UP  = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  // Shared counter: reset length, WAIT_RDY timeout, lock count, error count.
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  // TRAIN needs its timeout alongside the lock count, hence a second counter.
  logic [19:0] r_tmo;
  logic [19:0] w_tmo_nxt;
  logic [19:0] w_cnt_inc;
  logic        w_force_reset;
  logic        w_loop_chg;
  logic        w_rx_idle;
  logic        w_accept;

  logic        r_phy_rst;
  logic [15:0] r_tx_data;
  logic [1:0]  r_tx_k;
  logic        r_tx_ready;
  logic [15:0] r_rx_data;
  logic [1:0]  r_rx_k;
  logic        r_rx_valid;
  logic        r_link_up;
  logic        r_fault;

  //--------------------------------------------------------------------------
  // Optional serial loopback
  //--------------------------------------------------------------------------
`ifdef WR_PHY_LINK_CTRL_LOOPBACK_EN
  logic r_loopen;

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) r_loopen <= 1'b0;
    else          r_loopen <= loopback_req_i;
  end

  // Any change of the request retrains the link on the new path.
  assign w_loop_chg   = (loopback_req_i != r_loopen);
  assign phy_loopen_o = r_loopen;
`else
  logic w_unused_loopback;

  assign w_unused_loopback = loopback_req_i;
  assign w_loop_chg        = 1'b0;
  assign phy_loopen_o      = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // RX idle recognition and MAC handshake
  //--------------------------------------------------------------------------
  assign w_rx_idle = (phy_rx_k_i == 2'b10) && (phy_rx_data_i[15:8] == 8'hBC) &&
                     ((phy_rx_data_i[7:0] == 8'hC5) || (phy_rx_data_i[7:0] == 8'h50)) &&
                     !phy_rx_enc_err_i;
  assign w_accept      = mac.mac_tx_valid_i && r_tx_ready;
  assign w_force_reset = !enable_i || w_loop_chg;
  assign w_cnt_inc     = r_cnt + 20'd1;

  //--------------------------------------------------------------------------
  // FSM next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_tmo_nxt   = 20'd0;

    case (r_state)
      ST_RESET: begin
        if (r_cnt == c_reset_cycles - 20'd1) w_state_nxt = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (phy_rdy_i)                   w_state_nxt = ST_TRAIN;
        else if (w_cnt_inc == c_timeout) w_state_nxt = ST_FAULT;
      end
      ST_TRAIN: begin
        w_tmo_nxt = r_tmo + 20'd1;
        if (!w_rx_idle) w_cnt_nxt = 20'd0;
        // Lock is tested first so it wins over a simultaneous timeout.
        if (w_rx_idle && (w_cnt_inc == c_lock_count)) w_state_nxt = ST_LINK_UP;
        else if (w_tmo_nxt == c_timeout)              w_state_nxt = ST_FAULT;
      end
      ST_LINK_UP: begin
        if (!phy_rx_enc_err_i) w_cnt_nxt = 20'd0;
        if (!phy_rdy_i || (phy_rx_enc_err_i && (w_cnt_inc == c_err_threshold)))
          w_state_nxt = ST_RESET;
      end
      ST_FAULT: begin
        w_cnt_nxt = r_cnt;
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase

    if (w_force_reset) w_state_nxt = ST_RESET;

    // Counters restart on every state entry; enable low holds them at zero.
    if (w_force_reset || (w_state_nxt != r_state)) begin
      w_cnt_nxt = 20'd0;
      w_tmo_nxt = 20'd0;
    end
  end

  //--------------------------------------------------------------------------
  // State, counters and registered outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_RESET;
      r_cnt      <= 20'd0;
      r_tmo      <= 20'd0;
      r_phy_rst  <= 1'b1;
      r_tx_data  <= c_idle_neg;
      r_tx_k     <= c_idle_k;
      r_tx_ready <= 1'b0;
      r_rx_data  <= 16'd0;
      r_rx_k     <= 2'd0;
      r_rx_valid <= 1'b0;
      r_link_up  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
      // Status outputs are registered from the next state so they line up
      // with state_o.
      r_phy_rst  <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_FAULT);
      r_tx_ready <= (w_state_nxt == ST_LINK_UP);
      r_link_up  <= (w_state_nxt == ST_LINK_UP);
      r_fault    <= (w_state_nxt == ST_FAULT);

      if (w_accept) begin
        r_tx_data <= mac.mac_tx_data_i;
        r_tx_k    <= mac.mac_tx_k_i;
      end else begin
        r_tx_data <= phy_tx_disparity_i ? c_idle_pos : c_idle_neg;
        r_tx_k    <= c_idle_k;
      end

      r_rx_data  <= phy_rx_data_i;
      r_rx_k     <= phy_rx_k_i;
      // Valid only for clean words received in LINK_UP while staying there.
      r_rx_valid <= (r_state == ST_LINK_UP) && (w_state_nxt == ST_LINK_UP) &&
                    !phy_rx_enc_err_i;
    end
  end

  assign state_o            = r_state;
  assign phy_rst_o          = r_phy_rst;
  assign phy_tx_data_o      = r_tx_data;
  assign phy_tx_k_o         = r_tx_k;
  assign link_up_o          = r_link_up;
  assign fault_o            = r_fault;
  assign mac.mac_tx_ready_o = r_tx_ready;
  assign mac.mac_rx_data_o  = r_rx_data;
  assign mac.mac_rx_k_o     = r_rx_k;
  assign mac.mac_rx_valid_o = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_wr_phy_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_phy_link_ctrl
// Description : Directed self-checking bench for wr_phy_link_ctrl. RX is
//               normally looped back from TX; the error-drop scenario drives
//               RX words directly.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wr_phy_link_ctrl;

  localparam logic [44:0] c_rst_vec = {3'd0, 1'b1, 16'hBC50, 2'b10, 1'b0,
                                       16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        phy_rdy;
  logic        disparity;
  logic        enc_err;
  logic        loop_req;
  logic        rx_loop;
  logic [15:0] rx_man_data;
  logic [1:0]  rx_man_k;

  logic        phy_rst;
  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic [15:0] rx_data;
  logic [1:0]  rx_k;
  logic        link_up;
  logic        fault;
  logic [2:0]  state;
  logic        loopen;
  logic [44:0] all_outs;

  int n_vec = 0;
  int n_err = 0;

  always #8 clk = ~clk;

  wr_phy_link_ctrl_if mac_if ();

  assign rx_data = rx_loop ? tx_data : rx_man_data;
  assign rx_k    = rx_loop ? tx_k    : rx_man_k;
  assign all_outs = {state, phy_rst, tx_data, tx_k, mac_if.mac_tx_ready_o,
                     mac_if.mac_rx_data_o, mac_if.mac_rx_k_o, mac_if.mac_rx_valid_o,
                     link_up, fault, loopen};

  wr_phy_link_ctrl #(
    .g_reset_cycles (16),
    .g_lock_count   (64),
    .g_err_threshold(4),
    .g_timeout      (100)
  ) dut (
    .clk_ref_i         (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .phy_rst_o         (phy_rst),
    .phy_rdy_i         (phy_rdy),
    .phy_tx_data_o     (tx_data),
    .phy_tx_k_o        (tx_k),
    .phy_tx_disparity_i(disparity),
    .phy_rx_data_i     (rx_data),
    .phy_rx_k_i        (rx_k),
    .phy_rx_enc_err_i  (enc_err),
    .mac               (mac_if.slave),
    .link_up_o         (link_up),
    .fault_o           (fault),
    .state_o           (state),
    .loopback_req_i    (loop_req),
    .phy_loopen_o      (loopen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n                 = 1'b1;
    enable                = 1'b1;
    phy_rdy               = 1'b0;
    disparity             = 1'b0;
    enc_err               = 1'b0;
    loop_req              = 1'b0;
    rx_loop               = 1'b1;
    rx_man_data           = 16'hBC50;
    rx_man_k              = 2'b10;
    mac_if.mac_tx_data_i  = 16'h0000;
    mac_if.mac_tx_k_i     = 2'b00;
    mac_if.mac_tx_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs !== c_rst_vec) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", all_outs, c_rst_vec);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_bringup();
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) begin
        n_vec++;
        if ({state, phy_rst} !== {3'd0, 1'b1}) begin
          n_err++;
          $display("FAIL reset_hold: got state %0d rst %b expected 0 1", state, phy_rst);
        end
      end
    end
    tick();
    n_vec++;
    if ({state, phy_rst} !== {3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL wait_rdy_entry: got state %0d rst %b expected 1 0", state, phy_rst);
    end
    tick();
    tick();
    tick();
    phy_rdy = 1'b1;
    tick();
    n_vec++;
    if (state !== 3'd2) begin
      n_err++;
      $display("FAIL train_entry: got state %0d expected 2", state);
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 63) begin
        n_vec++;
        if ({state, link_up} !== {3'd2, 1'b0}) begin
          n_err++;
          $display("FAIL lock_early: got state %0d link %b expected 2 0", state, link_up);
        end
      end
    end
    n_vec++;
    if ({state, link_up, mac_if.mac_tx_ready_o} !== {3'd3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL link_up: got state %0d link %b ready %b expected 3 1 1",
               state, link_up, mac_if.mac_tx_ready_o);
    end
  endtask

  task automatic test_mac_arbitration();
    mac_if.mac_tx_data_i  = 16'h1234;
    mac_if.mac_tx_k_i     = 2'b00;
    mac_if.mac_tx_valid_i = 1'b1;
    tick();
    mac_if.mac_tx_valid_i = 1'b0;
    n_vec++;
    if ({tx_data, tx_k} !== {16'h1234, 2'b00}) begin
      n_err++;
      $display("FAIL mac_word: got %h/%b expected 1234/00", tx_data, tx_k);
    end
    tick();
    n_vec++;
    if ({tx_data, tx_k} !== {16'hBC50, 2'b10}) begin
      n_err++;
      $display("FAIL idle_after_mac: got %h/%b expected bc50/10", tx_data, tx_k);
    end
    n_vec++;
    if ({mac_if.mac_rx_data_o, mac_if.mac_rx_k_o, mac_if.mac_rx_valid_o} !== {16'h1234, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL rx_forward: got %h/%b/%b expected 1234/00/1",
               mac_if.mac_rx_data_o, mac_if.mac_rx_k_o, mac_if.mac_rx_valid_o);
    end
  endtask

  task automatic test_error_drop();
    logic [7:0] errs;
    logic [2:0] exp_state;
    errs    = 8'b1111_0111; // bit i = error flag of word i
    rx_loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enc_err = errs[i];
      tick();
      exp_state = (i == 7) ? 3'd0 : 3'd3;
      n_vec++;
      if ({state, mac_if.mac_rx_valid_o} !== {exp_state, ~errs[i]}) begin
        n_err++;
        $display("FAIL err_word_%0d: got state %0d valid %b expected %0d %b",
                 i, state, mac_if.mac_rx_valid_o, exp_state, ~errs[i]);
      end
    end
    n_vec++;
    if ({link_up, mac_if.mac_tx_ready_o} !== 2'b00) begin
      n_err++;
      $display("FAIL err_drop_status: got link %b ready %b expected 0 0",
               link_up, mac_if.mac_tx_ready_o);
    end
    enc_err = 1'b0;
    rx_loop = 1'b1;
  endtask

  task automatic test_disparity();
    bit         ok;
    logic [4:0] seq;
    logic [15:0] exp_word;
    seq = 5'b01101;
    wait_state(3'd2, 60, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL retrain_entry: got state %0d expected 2", state);
    end
    for (int i = 0; i < 5; i++) begin
      disparity = seq[i];
      tick();
      exp_word = seq[i] ? 16'hBCC5 : 16'hBC50;
      n_vec++;
      if ({tx_data, tx_k} !== {exp_word, 2'b10}) begin
        n_err++;
        $display("FAIL idle_disp_%0d: got %h/%b expected %h/10", i, tx_data, tx_k, exp_word);
      end
    end
    disparity = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    phy_rdy = 1'b0;
    enable  = 1'b0;
    tick();
    n_vec++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL enable_low: got state %0d expected 0", state);
    end
    enable = 1'b1;
    wait_state(3'd1, 40, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL wait_rdy_reach: got state %0d expected 1", state);
    end
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 99) begin
        n_vec++;
        if (state !== 3'd1) begin
          n_err++;
          $display("FAIL timeout_early: got state %0d expected 1", state);
        end
      end
    end
    n_vec++;
    if ({state, fault, phy_rst} !== {3'd4, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL fault_entry: got state %0d fault %b rst %b expected 4 1 1",
               state, fault, phy_rst);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    n_vec++;
    if ({state, fault} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL fault_exit: got state %0d fault %b expected 0 0", state, fault);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    phy_rdy = 1'b1;
    wait_state(3'd3, 200, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL relink: got state %0d expected 3", state);
    end
    mac_if.mac_tx_data_i  = 16'hA5A5;
    mac_if.mac_tx_k_i     = 2'b00;
    mac_if.mac_tx_valid_i = 1'b1;
    tick();
    tick();
    n_vec++;
    if (tx_data !== 16'hA5A5) begin
      n_err++;
      $display("FAIL traffic: got %h expected a5a5", tx_data);
    end
    #4;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs !== c_rst_vec) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", all_outs, c_rst_vec);
    end
    mac_if.mac_tx_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({state, phy_rst} !== {3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL restart: got state %0d rst %b expected 0 1", state, phy_rst);
    end
    wait_state(3'd3, 200, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL relink_after_reset: got state %0d expected 3", state);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_mac_arbitration();
    test_error_drop();
    test_disparity();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
